// File: rtl/multicycle_controller.sv
// Purpose : Moore control FSM for the 8-bit multicycle datapath (fetch / decode / execute / writeback).
// Latency : selects and enables decode the current state in the same cycle; next state is registered.
// Backpress: FETCHk, LBRD and SBWR hold while mem_ready=0; fetch enables are gated by mem_ready.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   op, zero, mem_ready     opcode, ALU zero flag, memory completion handshake
//   memread, memwrite       memory strobes
//   iord, alusrca, alusrcb  address / ALU operand mux selects
//   aluop, pcsrc            ALU op class, PC source select
//   pcen, regwrite          PC and register-file write enables
//   regdst, memtoreg        write-register / write-data mux selects
//   irwrite                 one-hot instruction-register byte enable
//   state_o                 current state encoding (debug)
module multicycle_controller #(
    parameter int FETCH_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   memread,
    output logic                   memwrite,
    output logic                   iord,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [1:0]             pcsrc,
    output logic                   pcen,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic [FETCH_BEATS-1:0] irwrite,
    output logic [3:0]             state_o
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_q, state_d;
    logic [2:0] beat;
    logic       in_fetch;

    // FETCHk states occupy encodings 0..3; beats beyond FETCH_BEATS are
    // unreachable and treated like any other unused encoding.
    assign beat     = {1'b0, state_q[1:0]};
    assign in_fetch = (state_q[3:2] == 2'b00) && (beat < 3'(FETCH_BEATS));

    always_comb begin
        state_d = S_FETCH1;
        if (in_fetch) begin
            if (!mem_ready)
                state_d = state_q;
            else if (beat == 3'(FETCH_BEATS - 1))
                state_d = S_DECODE;
            else
                state_d = state_t'(state_q + 4'd1);
        end else begin
            case (state_q)
                S_DECODE: begin
                    case (op)
                        OP_LB, OP_SB: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_RTYPEEX;
                        OP_BEQ:       state_d = S_BEQEX;
                        OP_J:         state_d = S_JEX;
                        OP_ADDI:      state_d = S_ADDIEX;
                        default:      state_d = S_FETCH1;
                    endcase
                end
                S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
                S_LBRD:    state_d = mem_ready ? S_LBWR : S_LBRD;
                S_SBWR:    state_d = mem_ready ? S_FETCH1 : S_SBWR;
                S_RTYPEEX: state_d = S_RTYPEWR;
                S_ADDIEX:  state_d = S_ADDIWR;
                default:   state_d = S_FETCH1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH1;
        else
            state_q <= state_d;
    end

    // Outputs decode only the registered state (plus the zero / mem_ready
    // qualifiers); reset forces every enable and select low in its cycle.
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        irwrite  = '0;
        if (!reset) begin
            if (in_fetch) begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcen    = mem_ready;
                irwrite = mem_ready ? (FETCH_BEATS'(1) << beat) : '0;
            end else begin
                case (state_q)
                    S_DECODE:  alusrcb = 2'b11;
                    S_MEMADR: begin
                        alusrca = 1'b1;
                        alusrcb = 2'b10;
                    end
                    S_LBRD: begin
                        memread = 1'b1;
                        iord    = 1'b1;
                    end
                    S_LBWR: begin
                        regwrite = 1'b1;
                        memtoreg = 1'b1;
                    end
                    S_SBWR: begin
                        memwrite = 1'b1;
                        iord     = 1'b1;
                    end
                    S_RTYPEEX: begin
                        alusrca = 1'b1;
                        aluop   = 2'b10;
                    end
                    S_RTYPEWR: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                    end
                    S_BEQEX: begin
                        alusrca = 1'b1;
                        aluop   = 2'b01;
                        pcsrc   = 2'b01;
                        pcen    = zero;
                    end
                    S_JEX: begin
                        pcsrc = 2'b10;
                        pcen  = 1'b1;
                    end
                    S_ADDIEX: begin
                        alusrca = 1'b1;
                        alusrcb = 2'b10;
                    end
                    S_ADDIWR:  regwrite = 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : directed-vector scoreboard bench for multicycle_controller (FETCH_BEATS=4).
// Latency : one expected output vector is queued per stimulus cycle and checked mid-cycle.
// Backpress: exercises mem_ready stalls in FETCH2, LBRD and SBWR, plus reset during a stall.
module tb_multicycle_controller;

    localparam logic [3:0] S_FETCH1 = 4'd0, S_DECODE = 4'd4, S_MEMADR = 4'd5,
                           S_LBRD = 4'd6, S_LBWR = 4'd7, S_SBWR = 4'd8,
                           S_RTYPEEX = 4'd9, S_RTYPEWR = 4'd10, S_BEQEX = 4'd11,
                           S_JEX = 4'd12, S_ADDIEX = 4'd13, S_ADDIWR = 4'd14;
    localparam logic [5:0] OP_R = 6'b000000, OP_LB = 6'b100000, OP_SB = 6'b101000,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ILL = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'd0;
    logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] irwrite, state_o;

    multicycle_controller #(.FETCH_BEATS(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .irwrite(irwrite), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       memread, memwrite, iord, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic       pcen, regwrite, regdst, memtoreg;
        logic [3:0] irwrite;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    vec_t  act;

    assign act = {state_o, memread, memwrite, iord, alusrca, alusrcb, aluop, pcsrc,
                  pcen, regwrite, regdst, memtoreg, irwrite};

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        vec_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d rd=%b wr=%b iord=%b a=%b b=%b op=%b pcs=%b pcen=%b rw=%b rd=%b m2r=%b ir=%b ; want st=%0d rd=%b wr=%b iord=%b a=%b b=%b op=%b pcs=%b pcen=%b rw=%b rd=%b m2r=%b ir=%b",
                         nm, act.st, act.memread, act.memwrite, act.iord, act.alusrca, act.alusrcb,
                         act.aluop, act.pcsrc, act.pcen, act.regwrite, act.regdst, act.memtoreg, act.irwrite,
                         e.st, e.memread, e.memwrite, e.iord, e.alusrca, e.alusrcb,
                         e.aluop, e.pcsrc, e.pcen, e.regwrite, e.regdst, e.memtoreg, e.irwrite);
            end
        end
    end

    // Hand-written expected vectors, one per state as described for the controller.
    function automatic vec_t v_idle(input logic [3:0] st);
        vec_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic vec_t v_fetch(input int k, input logic mr);
        vec_t e = v_idle(4'(k - 1));
        e.memread = 1'b1;
        e.alusrcb = 2'b01;
        e.pcen    = mr;
        e.irwrite = mr ? (4'(1) << (k - 1)) : 4'b0000;
        return e;
    endfunction

    function automatic vec_t v_state(input logic [3:0] st, input logic z);
        vec_t e = v_idle(st);
        case (st)
            S_DECODE:  e.alusrcb = 2'b11;
            S_MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_LBRD:    begin e.memread = 1'b1; e.iord = 1'b1; end
            S_LBWR:    begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            S_SBWR:    begin e.memwrite = 1'b1; e.iord = 1'b1; end
            S_RTYPEEX: begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            S_RTYPEWR: begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            S_BEQEX:   begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
            S_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            S_ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_ADDIWR:  e.regwrite = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    // Drive one cycle's inputs just after the edge and queue the expected outputs.
    task automatic step(input string nm, input logic r, input logic [5:0] o,
                        input logic z, input logic mr, input vec_t e);
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch_all(input string nm, input logic [5:0] o);
        for (int k = 1; k <= 4; k++)
            step($sformatf("%s_fetch%0d", nm, k), 1'b0, o, 1'b0, 1'b1, v_fetch(k, 1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        // First reset edge establishes FETCH1; second reset cycle checks forced-low outputs.
        @(posedge clk);
        step("reset_hold", 1'b1, OP_R, 1'b0, 1'b1, v_idle(S_FETCH1));

        // R-type; op toggled during execute must not matter.
        fetch_all("rtype", 6'b110011);
        step("rtype_dec", 1'b0, OP_R,   1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("rtype_ex",  1'b0, OP_ILL, 1'b0, 1'b1, v_state(S_RTYPEEX, 1'b0));
        step("rtype_wr",  1'b0, OP_ILL, 1'b0, 1'b1, v_state(S_RTYPEWR, 1'b0));

        // LB with three stall cycles in LBRD.
        fetch_all("lb", OP_LB);
        step("lb_dec",    1'b0, OP_LB, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("lb_adr",    1'b0, OP_LB, 1'b0, 1'b1, v_state(S_MEMADR, 1'b0));
        for (int i = 0; i < 3; i++)
            step($sformatf("lb_rd_stall%0d", i), 1'b0, OP_R, 1'b0, 1'b0, v_state(S_LBRD, 1'b0));
        step("lb_rd_go",  1'b0, OP_R, 1'b0, 1'b1, v_state(S_LBRD, 1'b0));
        step("lb_wr",     1'b0, OP_R, 1'b0, 1'b1, v_state(S_LBWR, 1'b0));

        // BEQ taken and not taken.
        fetch_all("beq1", OP_BEQ);
        step("beq1_dec",  1'b0, OP_BEQ, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("beq1_ex",   1'b0, OP_BEQ, 1'b1, 1'b1, v_state(S_BEQEX, 1'b1));
        fetch_all("beq0", OP_BEQ);
        step("beq0_dec",  1'b0, OP_BEQ, 1'b1, 1'b1, v_state(S_DECODE, 1'b0));
        step("beq0_ex",   1'b0, OP_BEQ, 1'b0, 1'b1, v_state(S_BEQEX, 1'b0));

        // Illegal opcode: decode then straight back to fetch.
        fetch_all("ill", OP_ILL);
        step("ill_dec",   1'b0, OP_ILL, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));

        // Jump.
        fetch_all("j", OP_J);
        step("j_dec",     1'b0, OP_J, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("j_ex",      1'b0, OP_J, 1'b0, 1'b1, v_state(S_JEX, 1'b0));

        // ADDI.
        fetch_all("addi", OP_ADDI);
        step("addi_dec",  1'b0, OP_ADDI, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("addi_ex",   1'b0, OP_ADDI, 1'b0, 1'b1, v_state(S_ADDIEX, 1'b0));
        step("addi_wr",   1'b0, OP_ADDI, 1'b0, 1'b1, v_state(S_ADDIWR, 1'b0));

        // SB completing after one stall.
        fetch_all("sb", OP_SB);
        step("sb_dec",    1'b0, OP_SB, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("sb_adr",    1'b0, OP_SB, 1'b0, 1'b1, v_state(S_MEMADR, 1'b0));
        step("sb_stall",  1'b0, OP_SB, 1'b0, 1'b0, v_state(S_SBWR, 1'b0));
        step("sb_go",     1'b0, OP_SB, 1'b0, 1'b1, v_state(S_SBWR, 1'b0));

        // SB stalled, then reset while stalled.
        fetch_all("sbr", OP_SB);
        step("sbr_dec",   1'b0, OP_SB, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("sbr_adr",   1'b0, OP_SB, 1'b0, 1'b1, v_state(S_MEMADR, 1'b0));
        step("sbr_stall0",1'b0, OP_SB, 1'b0, 1'b0, v_state(S_SBWR, 1'b0));
        step("sbr_stall1",1'b0, OP_SB, 1'b0, 1'b0, v_state(S_SBWR, 1'b0));
        step("sbr_reset", 1'b1, OP_SB, 1'b0, 1'b0, v_idle(S_SBWR));

        // FETCH2 stalled for two cycles, then finish an R-type.
        step("fs_fetch1", 1'b0, OP_R, 1'b0, 1'b1, v_fetch(1, 1'b1));
        step("fs_stall0", 1'b0, OP_R, 1'b0, 1'b0, v_fetch(2, 1'b0));
        step("fs_stall1", 1'b0, OP_R, 1'b0, 1'b0, v_fetch(2, 1'b0));
        step("fs_fetch2", 1'b0, OP_R, 1'b0, 1'b1, v_fetch(2, 1'b1));
        step("fs_fetch3", 1'b0, OP_R, 1'b0, 1'b1, v_fetch(3, 1'b1));
        step("fs_fetch4", 1'b0, OP_R, 1'b0, 1'b1, v_fetch(4, 1'b1));
        step("fs_dec",    1'b0, OP_R, 1'b0, 1'b1, v_state(S_DECODE, 1'b0));
        step("fs_ex",     1'b0, OP_R, 1'b0, 1'b1, v_state(S_RTYPEEX, 1'b0));
        step("fs_wr",     1'b0, OP_R, 1'b0, 1'b1, v_state(S_RTYPEWR, 1'b0));
        step("fs_back",   1'b0, OP_R, 1'b0, 1'b1, v_fetch(1, 1'b1));

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
